free_list: RTL and testbench

//  Physical-register free list for the R10K-style rename stage. Supplies up to two free

---
 rtl/panda_pkg.sv | 20 ++
 rtl/free_list_if.sv | 39 +++
 rtl/free_list.sv | 97 +++++++++
 tb/tb_free_list.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/panda_pkg.sv
// Shared sizing and helper definitions for the rename-stage physical register free list.
package panda_pkg;

    localparam int NUM_PR   = 64;
    localparam int NUM_AR   = 32;
    localparam int TAG_W    = 7;
    localparam int NUM_FREE = NUM_PR - NUM_AR;
    localparam int FL_PTR_W = $clog2(NUM_FREE);
    localparam int FL_CNT_W = FL_PTR_W + 1;

    typedef logic [TAG_W-1:0]    tag_t;
    typedef logic [FL_PTR_W-1:0] fl_ptr_t;
    typedef logic [FL_CNT_W-1:0] fl_cnt_t;

    // A per-cycle count of 3 is not a legal request; it is treated as 2.
    function automatic logic [1:0] saturateNum(input logic [1:0] num);
        return (num == 2'd3) ? 2'd2 : num;
    endfunction

endpackage

// File: rtl/free_list_if.sv
// Dispatch / retire / flush bundle between the ROB-side logic (master) and the free list (slave).
interface free_list_if;
    import panda_pkg::*;

    logic [1:0] rs_mt_fl_dispatch_num;
    tag_t       fl_retire_tag_a;
    tag_t       fl_retire_tag_b;
    logic [1:0] fl_retire_num;
    logic       flush;
    tag_t       fl_pr0;
    tag_t       fl_pr1;
    logic [1:0] fl_avail;
    fl_cnt_t    fl_count;

    modport master (
        output rs_mt_fl_dispatch_num,
        output fl_retire_tag_a,
        output fl_retire_tag_b,
        output fl_retire_num,
        output flush,
        input  fl_pr0,
        input  fl_pr1,
        input  fl_avail,
        input  fl_count
    );

    modport slave (
        input  rs_mt_fl_dispatch_num,
        input  fl_retire_tag_a,
        input  fl_retire_tag_b,
        input  fl_retire_num,
        input  flush,
        output fl_pr0,
        output fl_pr1,
        output fl_avail,
        output fl_count
    );

endinterface

// File: rtl/free_list.sv
// Physical-register free list: circular FIFO of free tags with dispatch head, retire tail,
// and a committed head used to recover all in-flight allocations in one cycle on flush.
module free_list
    import panda_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    free_list_if.slave  fl
);

    tag_t    entry_q [NUM_FREE];
    fl_ptr_t head_q, head_d;
    fl_ptr_t tail_q, tail_d;
    fl_ptr_t archHead_q, archHead_d;
    fl_cnt_t count_q, count_d;

    fl_ptr_t headPlus1;
    fl_ptr_t tailPlus1;
    logic [1:0] avail;
    logic [1:0] dispReq;
    logic [1:0] dispNum;
    logic [1:0] retNum;
    logic [FL_CNT_W:0] countAfter;

    assign headPlus1 = head_q + fl_ptr_t'(1);
    assign tailPlus1 = tail_q + fl_ptr_t'(1);

    // Outputs come only from registered state, so retired tags are never bypassed to dispatch.
    assign fl.fl_pr0   = entry_q[head_q];
    assign fl.fl_pr1   = entry_q[headPlus1];
    assign fl.fl_avail = avail;
    assign fl.fl_count = count_q;

    // Legalise the request counts: saturate 3 to 2 and never hand out more tags than are held.
    always_comb begin
        avail   = (count_q >= fl_cnt_t'(2)) ? 2'd2 : count_q[1:0];
        dispReq = saturateNum(fl.rs_mt_fl_dispatch_num);
        dispNum = (dispReq > avail) ? avail : dispReq;
        retNum  = saturateNum(fl.fl_retire_num);
    end

    // Next pointer and count values; a flush rewinds head to the committed point and refills.
    always_comb begin
        tail_d     = tail_q + fl_ptr_t'(retNum);
        archHead_d = archHead_q + fl_ptr_t'(retNum);
        countAfter = {1'b0, count_q} + (FL_CNT_W+1)'(retNum) - (FL_CNT_W+1)'(dispNum);
        if (fl.flush) begin
            head_d  = archHead_d;
            count_d = fl_cnt_t'(NUM_FREE);
        end else begin
            head_d  = head_q + fl_ptr_t'(dispNum);
            count_d = countAfter[FL_CNT_W-1:0];
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            archHead_q <= '0;
            count_q    <= fl_cnt_t'(NUM_FREE);
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            archHead_q <= archHead_d;
            count_q    <= count_d;
        end
    end

    // Tag storage: reset holds the non-architected tags in order; retire writes up to two slots at tail.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_FREE; i++) begin
                entry_q[i] <= tag_t'(NUM_AR + i);
            end
        end else begin
            if (retNum != 2'd0) begin
                entry_q[tail_q] <= fl.fl_retire_tag_a;
            end
            if (retNum == 2'd2) begin
                entry_q[tailPlus1] <= fl.fl_retire_tag_b;
            end
        end
    end

    // Protocol checks on the ROB side of the interface.
    dispatchWithinAvail: assert property (@(posedge clock) disable iff (!reset)
        (!fl.flush) |-> (fl.rs_mt_fl_dispatch_num <= avail));

    numsNotThree: assert property (@(posedge clock) disable iff (!reset)
        (fl.rs_mt_fl_dispatch_num != 2'd3) && (fl.fl_retire_num != 2'd3));

    noOverflow: assert property (@(posedge clock) disable iff (!reset)
        ((retNum != 2'd0) && !fl.flush) |-> (countAfter <= (FL_CNT_W+1)'(NUM_FREE)));

endmodule

// File: tb/tb_free_list.sv
// Directed scoreboard bench for the free list: a queue-based reference FIFO predicts outputs.
module tb_free_list;
    import panda_pkg::*;

    typedef struct {
        int         step;
        tag_t       pr0;
        tag_t       pr1;
        logic [1:0] avail;
        fl_cnt_t    count;
        bit         chk0;
        bit         chk1;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    free_list_if flIf ();

    free_list dut (
        .clock (clock),
        .reset (reset),
        .fl    (flIf.slave)
    );

    // Free-running clock, 10 time units per period.
    always #5 clock = ~clock;

    exp_t expQ[$];
    tag_t freeQ[$];
    tag_t inflightQ[$];
    int   assertCount = 0;
    int   failCount   = 0;
    int   stepNum     = 0;

    // Reference state after reset: non-architected tags in ascending order, nothing in flight.
    function automatic void modelReset();
        freeQ.delete();
        inflightQ.delete();
        for (int i = 0; i < NUM_FREE; i++) begin
            freeQ.push_back(tag_t'(NUM_AR + i));
        end
    endfunction

    // Record what the outputs must show for the current reference state.
    function automatic void pushExpected();
        exp_t e;
        e.step  = stepNum;
        e.count = fl_cnt_t'(freeQ.size());
        e.avail = (freeQ.size() >= 2) ? 2'd2 : 2'(freeQ.size());
        e.chk0  = (freeQ.size() >= 1);
        e.chk1  = (freeQ.size() >= 2);
        e.pr0   = e.chk0 ? freeQ[0] : '0;
        e.pr1   = e.chk1 ? freeQ[1] : '0;
        expQ.push_back(e);
    endfunction

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $error("[TB] FAIL scoreboard_empty observed=0 entries expected>=1");
            return;
        end
        e = expQ.pop_front();
        assertCount++;
        assert (flIf.fl_count === e.count) else begin
            failCount++;
            $error("[TB] FAIL step%0d.count observed=%0d expected=%0d", e.step, flIf.fl_count, e.count);
        end
        assertCount++;
        assert (flIf.fl_avail === e.avail) else begin
            failCount++;
            $error("[TB] FAIL step%0d.avail observed=%0d expected=%0d", e.step, flIf.fl_avail, e.avail);
        end
        if (e.chk0) begin
            assertCount++;
            assert (flIf.fl_pr0 === e.pr0) else begin
                failCount++;
                $error("[TB] FAIL step%0d.pr0 observed=%0d expected=%0d", e.step, flIf.fl_pr0, e.pr0);
            end
        end
        if (e.chk1) begin
            assertCount++;
            assert (flIf.fl_pr1 === e.pr1) else begin
                failCount++;
                $error("[TB] FAIL step%0d.pr1 observed=%0d expected=%0d", e.step, flIf.fl_pr1, e.pr1);
            end
        end
    endtask

    task automatic checkConst(input string name, input int observed, input int expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", name, observed, expected);
        end
    endtask

    // One clock step: outputs must not react to the new inputs before the edge, then match the model after it.
    task automatic applyStimulus(input logic [1:0] d, input logic [1:0] r,
                                 input tag_t ta, input tag_t tb, input logic fl);
        flIf.rs_mt_fl_dispatch_num = d;
        flIf.fl_retire_num         = r;
        flIf.fl_retire_tag_a       = ta;
        flIf.fl_retire_tag_b       = tb;
        flIf.flush                 = fl;
        #1;
        pushExpected();
        checkOutput();
        for (int k = 0; k < int'(r); k++) begin
            if (inflightQ.size() > 0) void'(inflightQ.pop_front());
        end
        if (r >= 2'd1) freeQ.push_back(ta);
        if (r == 2'd2) freeQ.push_back(tb);
        if (fl) begin
            freeQ = {inflightQ, freeQ};
            inflightQ.delete();
        end else begin
            for (int k = 0; k < int'(d); k++) begin
                inflightQ.push_back(freeQ.pop_front());
            end
        end
        pushExpected();
        @(posedge clock);
        #1;
        checkOutput();
        flIf.rs_mt_fl_dispatch_num = 2'd0;
        flIf.fl_retire_num         = 2'd0;
        flIf.flush                 = 1'b0;
        stepNum++;
    endtask

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        tag_t retTag;
        flIf.rs_mt_fl_dispatch_num = 2'd0;
        flIf.fl_retire_num         = 2'd0;
        flIf.fl_retire_tag_a       = '0;
        flIf.fl_retire_tag_b       = '0;
        flIf.flush                 = 1'b0;
        modelReset();

        // Reset state, then idle.
        #12;
        pushExpected();
        checkOutput();
        checkConst("reset.pr0", int'(flIf.fl_pr0), 32);
        checkConst("reset.pr1", int'(flIf.fl_pr1), 33);
        checkConst("reset.avail", int'(flIf.fl_avail), 2);
        checkConst("reset.count", int'(flIf.fl_count), 32);
        reset = 1'b1;
        @(posedge clock);
        #1;
        applyStimulus(2'd0, 2'd0, '0, '0, 1'b0);

        // Dispatch two per cycle for three cycles.
        for (int i = 0; i < 3; i++) applyStimulus(2'd2, 2'd0, '0, '0, 1'b0);
        checkConst("disp3.pr0", int'(flIf.fl_pr0), 38);
        checkConst("disp3.pr1", int'(flIf.fl_pr1), 39);
        checkConst("disp3.count", int'(flIf.fl_count), 26);

        // Drain to empty, then retire 4,5 which must not be visible until the next cycle.
        for (int i = 0; i < 13; i++) applyStimulus(2'd2, 2'd0, '0, '0, 1'b0);
        checkConst("empty.count", int'(flIf.fl_count), 0);
        checkConst("empty.avail", int'(flIf.fl_avail), 0);
        applyStimulus(2'd0, 2'd2, tag_t'(4), tag_t'(5), 1'b0);
        checkConst("refill.pr0", int'(flIf.fl_pr0), 4);
        checkConst("refill.pr1", int'(flIf.fl_pr1), 5);
        checkConst("refill.avail", int'(flIf.fl_avail), 2);

        // Simultaneous dispatch and retire keeps the count; then single-tag traffic at count 1.
        applyStimulus(2'd2, 2'd2, tag_t'(6), tag_t'(7), 1'b0);
        checkConst("dr.count", int'(flIf.fl_count), 2);
        applyStimulus(2'd1, 2'd0, '0, '0, 1'b0);
        checkConst("one.avail", int'(flIf.fl_avail), 1);
        applyStimulus(2'd1, 2'd1, tag_t'(8), '0, 1'b0);
        checkConst("one.pr0", int'(flIf.fl_pr0), 8);

        // Build occupancy, then wrap head and tail with one-in/one-out traffic.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'd0, 2'd2, tag_t'(20 + 2*i), tag_t'(21 + 2*i), 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            retTag = inflightQ[inflightQ.size()-1];
            applyStimulus(2'd1, 2'd1, retTag, '0, 1'b0);
        end
        applyStimulus(2'd2, 2'd1, tag_t'(50), '0, 1'b0);

        // Asynchronous reset mid-operation takes effect without a clock edge.
        reset = 1'b0;
        #2;
        modelReset();
        pushExpected();
        checkOutput();
        reset = 1'b1;
        #2;

        // Flush recovery: four allocations, one retire, then flush.
        applyStimulus(2'd2, 2'd0, '0, '0, 1'b0);
        applyStimulus(2'd2, 2'd0, '0, '0, 1'b0);
        applyStimulus(2'd0, 2'd1, tag_t'(4), '0, 1'b0);
        applyStimulus(2'd0, 2'd0, '0, '0, 1'b1);
        checkConst("flush.pr0", int'(flIf.fl_pr0), 33);
        checkConst("flush.count", int'(flIf.fl_count), 32);

        // Flush with a same-cycle retire and an ignored dispatch request.
        applyStimulus(2'd2, 2'd0, '0, '0, 1'b0);
        applyStimulus(2'd2, 2'd1, tag_t'(9), '0, 1'b1);
        checkConst("flushret.pr0", int'(flIf.fl_pr0), 34);
        checkConst("flushret.count", int'(flIf.fl_count), 32);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
